// File: rtl/spi_ram_burst.sv
// SPI-side RAM command engine: address/data loads, burst writes and handshaked reads.
// Optional per-word even parity is enabled by defining SPI_RAM_PARITY_EN.
module spi_ram_burst #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter bit          AUTO_INC  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ack,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              busy,
  output logic              addr_err,
  output logic              parity_err
);

`ifdef SPI_RAM_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif
  localparam int unsigned DepthCmpW = DATA_W + 1;
  localparam logic [DepthCmpW-1:0] DepthLimit = DepthCmpW'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    CmdWrAddr = 2'b00,
    CmdWrData = 2'b01,
    CmdRdAddr = 2'b10,
    CmdRdReq  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [MemW-1:0]   mem [MEM_DEPTH];

  cmd_e              cmd;
  logic [DATA_W-1:0] payload;
  logic              in_range;
  logic [MemW-1:0]   wr_word;

  assign cmd      = cmd_e'(din[DATA_W+1:DATA_W]);
  assign payload  = din[DATA_W-1:0];
  assign in_range = {1'b0, payload} < DepthLimit;

`ifdef SPI_RAM_PARITY_EN
  assign wr_word = {^payload, payload};
`else
  assign wr_word = payload;
`endif

  // Wrap is an explicit compare so non power-of-two depths work.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LastAddr) ? '0 : a + 1'b1;
  endfunction

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rx_valid && cmd == CmdWrData) begin
      mem[wr_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      addr_err <= 1'b0;
`ifdef SPI_RAM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      addr_err <= 1'b0;

      if (rx_valid) begin
        case (cmd)
          CmdWrAddr: begin
            if (in_range) wr_addr <= payload[ADDR_W-1:0];
            else          addr_err <= 1'b1;
          end
          CmdWrData: begin
            if (AUTO_INC) wr_addr <= wrap_inc(wr_addr);
          end
          CmdRdAddr: begin
            if (!in_range) addr_err <= 1'b1;
          end
          default: ;
        endcase
      end

      case (state)
        StIdle: begin
          if (rx_valid && cmd == CmdRdReq) begin
            state <= StFetch;
            busy  <= 1'b1;
          end
        end
        StFetch: begin
          state    <= StHold;
          dout     <= mem[rd_addr][DATA_W-1:0];
          tx_valid <= 1'b1;
          if (AUTO_INC) rd_addr <= wrap_inc(rd_addr);
`ifdef SPI_RAM_PARITY_EN
          parity_err <= ^mem[rd_addr];
`endif
        end
        StHold: begin
          if (tx_ack) begin
            state    <= StIdle;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
`ifdef SPI_RAM_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase

      // A read-address load overrides the fetch post-increment.
      if (rx_valid && cmd == CmdRdAddr && in_range) begin
        rd_addr <= payload[ADDR_W-1:0];
      end
    end
  end

`ifndef SPI_RAM_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_burst.sv
// Self-checking bench for spi_ram_burst: directed corner cases, a vector table and
// randomized traffic against a transaction-level memory model.
module tb_spi_ram_burst;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW+1:0] din = '0;
  logic          rx_valid = 1'b0;
  logic          tx_ack = 1'b0;
  logic [DW-1:0] dout;
  logic          tx_valid;
  logic          busy;
  logic          addr_err;
  logic          parity_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [DEPTH];
  int wr_m;
  int rd_m;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pay;
    logic       exp_err;
  } vec_t;
  vec_t vecs [6];

  spi_ram_burst #(
    .DATA_W   (DW),
    .MEM_DEPTH(DEPTH),
    .ADDR_W   (8),
    .AUTO_INC (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .rx_valid  (rx_valid),
    .tx_ack    (tx_ack),
    .dout      (dout),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .addr_err  (addr_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] pay);
    din = {cmd, pay};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Issue a read, hold the ack off for ack_delay HOLD cycles, then ack.
  task automatic do_read(input logic [7:0] exp, input int ack_delay);
    send(2'b11, 8'h00);
    chk("busy_after_req", busy, 1);
    chk("txv_in_fetch", tx_valid, 0);
    tick();
    chk("txv_hold", tx_valid, 1);
    chk("dout_hold", dout, exp);
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      chk("txv_wait", tx_valid, 1);
      chk("dout_wait", dout, exp);
    end
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("txv_after_ack", tx_valid, 0);
    chk("busy_after_ack", busy, 0);
  endtask

  initial begin
    vecs[0] = '{cmd: 2'b00, pay: 8'd199, exp_err: 1'b0};
    vecs[1] = '{cmd: 2'b00, pay: 8'd200, exp_err: 1'b1};
    vecs[2] = '{cmd: 2'b10, pay: 8'd255, exp_err: 1'b1};
    vecs[3] = '{cmd: 2'b10, pay: 8'd5,   exp_err: 1'b0};
    vecs[4] = '{cmd: 2'b00, pay: 8'd0,   exp_err: 1'b0};
    vecs[5] = '{cmd: 2'b10, pay: 8'd200, exp_err: 1'b1};

    tick();
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_parity_err", parity_err, 0);
    rst = 1'b0;
    tick();

    // Address range vectors: error pulse lasts exactly one cycle.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].cmd, vecs[i].pay);
      chk("vec_addr_err", addr_err, {31'd0, vecs[i].exp_err});
      tick();
      chk("vec_addr_err_clr", addr_err, 0);
    end

    // Burst write then burst read.
    send(2'b00, 8'h10);
    send(2'b01, 8'hA1);
    send(2'b01, 8'hA2);
    send(2'b01, 8'hA3);
    send(2'b10, 8'h10);
    do_read(8'hA1, 0);
    do_read(8'hA2, 0);
    do_read(8'hA3, 0);

    // Wrap at MEM_DEPTH-1 and rejected out-of-range write address.
    send(2'b00, 8'd199);
    send(2'b01, 8'h55);
    send(2'b01, 8'h66);
    send(2'b00, 8'd200);
    chk("wrap_addr_err", addr_err, 1);
    send(2'b01, 8'h77);
    chk("wrap_addr_err_clr", addr_err, 0);
    send(2'b10, 8'd199);
    do_read(8'h55, 0);
    do_read(8'h66, 0);
    do_read(8'h77, 0);

    // Long hold with a dropped read request.
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        din = {2'b11, 8'h00};
        rx_valid = 1'b1;
      end
      tick();
      rx_valid = 1'b0;
      chk("hold_txv", tx_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_dout", dout, 8'hA1);
    end
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("hold_busy_end", busy, 0);
    do_read(8'hA2, 1);

    // Write to the fetched address on the FETCH edge: old data returned.
    send(2'b00, 8'h20);
    send(2'b01, 8'h5A);
    send(2'b00, 8'h20);
    send(2'b10, 8'h20);
    send(2'b11, 8'h00);
    send(2'b01, 8'hFF);
    chk("coll_txv", tx_valid, 1);
    chk("coll_dout_old", dout, 8'h5A);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    send(2'b10, 8'h20);
    do_read(8'hFF, 0);

    // Read-address load on the FETCH edge beats the post-increment.
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    send(2'b10, 8'h10);
    chk("ld_fetch_dout", dout, 8'hA3);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    do_read(8'hA1, 0);

    // Ack together with a read request in HOLD: the request is dropped.
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    tick();
    din = {2'b11, 8'h00};
    rx_valid = 1'b1;
    tx_ack = 1'b1;
    tick();
    rx_valid = 1'b0;
    tx_ack = 1'b0;
    chk("ackreq_busy", busy, 0);
    chk("ackreq_txv", tx_valid, 0);
    tick();
    chk("ackreq_busy2", busy, 0);

    // Reset while holding read data.
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    tick();
    chk("rstmid_txv_pre", tx_valid, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_dout", dout, 0);
    chk("rstmid_txv", tx_valid, 0);
    chk("rstmid_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    do_read(8'h66, 0);

`ifdef SPI_RAM_PARITY_EN
    send(2'b00, 8'h30);
    send(2'b01, 8'h3C);
    dut.mem[8'h30][DW] = ~dut.mem[8'h30][DW];
    send(2'b10, 8'h30);
    send(2'b11, 8'h00);
    tick();
    chk("par_txv", tx_valid, 1);
    chk("par_err", parity_err, 1);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("par_err_clr", parity_err, 0);
`endif

    // Randomized traffic against the memory model.
    send(2'b00, 8'd0);
    for (int a = 0; a < int'(DEPTH); a++) begin
      mem_m[a] = 8'($urandom);
      send(2'b01, mem_m[a]);
    end
    wr_m = 0;
    rd_m = 0;
    send(2'b10, 8'd0);
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [7:0] p;
      op = $urandom_range(0, 3);
      p = 8'($urandom);
      case (op)
        0: begin
          send(2'b00, p);
          chk("rnd_wa_err", addr_err, {31'd0, (int'(p) >= int'(DEPTH))});
          if (int'(p) < int'(DEPTH)) wr_m = int'(p);
        end
        1: begin
          send(2'b01, p);
          mem_m[wr_m] = p;
          wr_m = (wr_m + 1) % int'(DEPTH);
        end
        2: begin
          send(2'b10, p);
          chk("rnd_ra_err", addr_err, {31'd0, (int'(p) >= int'(DEPTH))});
          if (int'(p) < int'(DEPTH)) rd_m = int'(p);
        end
        default: begin
          do_read(mem_m[rd_m], $urandom_range(0, 3));
          rd_m = (rd_m + 1) % int'(DEPTH);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised single-port synchronous RAM command engine sitting behind the SPI slave shift logic. Decodes 2-bit command plus DATA_W payload words from the SPI slave and supports write-address, write-data, read-address and read-request operations. Write and read addresses auto-increment for burst transfers. Read data is held with a valid/acknowledge handshake until the SPI slave has taken it.

## Interface
- DATA_W, 8, data word width; also the payload width.
- MEM_DEPTH, 256, number of words; any value from 2 to 2^ADDR_W.
- ADDR_W, 8, address register width; requires ADDR_W <= DATA_W.
- AUTO_INC, 1, 1 = post-increment addresses after each access; 0 = addresses static.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_W+2  din[DATA_W+1:DATA_W] = command; din[DATA_W-1:0] = payload.
- rx_valid  in  1  din valid for one cycle; commands act only when high.
- tx_ack  in  1  SPI slave has consumed dout; sampled only in HOLD.
- dout  out  DATA_W  read data.
- tx_valid  out  1  dout valid; held until acknowledged.
- busy  out  1  read in progress (FETCH or HOLD).
- addr_err  out  1  one-cycle pulse on an out-of-range address command.
- parity_err  out  1  read word failed parity check; always 0 without the macro.

## Operation
- Reset: dout=0, tx_valid=0, busy=0, addr_err=0, parity_err=0, wr_addr=0, rd_addr=0, state=IDLE. Memory contents are not reset.
- Cmd 00 (set write address): payload >= MEM_DEPTH pulses addr_err and leaves wr_addr unchanged; otherwise wr_addr = payload[ADDR_W-1:0]. Accepted in any state.
- Cmd 01 (write data): mem[wr_addr] = payload. If AUTO_INC, wr_addr increments and wraps from MEM_DEPTH-1 to 0. Accepted in any state.
- Cmd 10 (set read address): same range rule as cmd 00, applied to rd_addr. Accepted in any state.
- Cmd 11 (read request):
  - Accepted only in IDLE; moves to FETCH.
  - Dropped without side effects in FETCH or HOLD.
  - Payload is ignored.
- State machine:
  - IDLE -> FETCH on an accepted cmd 11.
  - FETCH -> HOLD unconditionally. On this edge dout = mem[rd_addr] and tx_valid = 1. If AUTO_INC, rd_addr increments with wrap.
  - HOLD -> IDLE when tx_ack = 1. On this edge tx_valid = 0 and parity_err = 0.
- Simultaneous events:
  - Cmd 10 on the FETCH edge: the loaded address wins and the post-increment is discarded.
  - Cmd 01 to the address being fetched, on the FETCH edge: dout returns the old data (read-before-write).
  - tx_ack together with cmd 11 in HOLD: the ack is taken and the read is dropped.
- Address arithmetic is done in ADDR_W bits. Wrap is an explicit compare against MEM_DEPTH-1, not a power-of-2 rollover.

## Timing
- Cmd 11 sampled at edge E: busy=1 after E, tx_valid=1 and dout valid after E+1. Read latency is 2 cycles.
- Minimum read cycle is 3 cycles (request, fetch, ack in the first HOLD cycle). Back-to-back read requests are possible from the cycle after the ack edge.
- Writes and address loads take effect at the sampling edge. A read issued the next cycle sees the new values.
- dout is stable for the whole of HOLD. dout retains its last value in IDLE.
- addr_err is high for exactly the cycle after the offending command.
- rst asserted mid-read: state returns to IDLE immediately, outputs take reset values, and no ack is required.

## Configuration
- SPI_RAM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on write.
  - On the FETCH edge parity is recomputed. parity_err = 1 on a mismatch, asserted alongside tx_valid and cleared with it.
- SPI_RAM_PARITY_EN undefined: no parity storage, and parity_err is tied to 0.

## Test plan
- Burst write, DATA_W=8, MEM_DEPTH=256: cmd00 0x10, then cmd01 with 0xA1, 0xA2, 0xA3. Cmd10 0x10, then three cmd11 each acked -> dout 0xA1, 0xA2, 0xA3, each with tx_valid 2 cycles after its request.
- Wrap, MEM_DEPTH=200: cmd00 199, then cmd01 with 0x55 and 0x66. Read addresses 199 and 0 -> 0x55 and 0x66. Cmd00 200 -> addr_err pulse and wr_addr unchanged.
- Handshake hold: read address 0x10 (0xA1), withhold tx_ack 10 cycles -> tx_valid and busy stay 1 with dout 0xA1. A second cmd11 during HOLD is dropped. The ack returns the block to IDLE and rd_addr = 0x11.
- Collision: in FETCH, cmd01 to the fetched address with 0xFF -> dout shows the old value. The next read of that address returns 0xFF.
- Reset mid-read: assert rst in HOLD -> dout=0, tx_valid=0, busy=0 immediately. After release, cmd11 reads from address 0.
- With SPI_RAM_PARITY_EN: write 0x3C, force the stored parity bit inverted, read -> parity_err=1 alongside tx_valid, cleared on ack.
